// File: rtl/ahb_lite_slave_arbiter_pkg.sv
// Shared AHB-Lite widths and encodings used by the slave-port arbiter and its
// round-robin encoder.
package ahb_lite_slave_arbiter_pkg;

    localparam int W_TRANS = 2;
    localparam int W_BURST = 3;
    localparam int W_SIZE  = 3;
    localparam int W_PROT  = 4;
    localparam int W_RESP  = 1;

    localparam logic [W_TRANS-1:0] TRANS_IDLE   = 2'b00;
    localparam logic [W_TRANS-1:0] TRANS_BUSY   = 2'b01;
    localparam logic [W_TRANS-1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [W_TRANS-1:0] TRANS_SEQ    = 2'b11;

    localparam logic [W_BURST-1:0] BURST_SINGLE = 3'b000;
    localparam logic [W_BURST-1:0] BURST_INCR   = 3'b001;
    localparam logic [W_BURST-1:0] BURST_WRAP4  = 3'b010;
    localparam logic [W_BURST-1:0] BURST_INCR4  = 3'b011;
    localparam logic [W_BURST-1:0] BURST_WRAP8  = 3'b100;
    localparam logic [W_BURST-1:0] BURST_INCR8  = 3'b101;
    localparam logic [W_BURST-1:0] BURST_WRAP16 = 3'b110;
    localparam logic [W_BURST-1:0] BURST_INCR16 = 3'b111;

    localparam logic [W_RESP-1:0] RESP_OKAY  = 1'b0;
    localparam logic [W_RESP-1:0] RESP_ERROR = 1'b1;

    // True for beats that move data (NONSEQ or SEQ).
    function automatic logic trans_is_xfer(input logic [W_TRANS-1:0] t);
        case (t)
            TRANS_NONSEQ, TRANS_SEQ: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

    // True for beats that sit inside a burst and must not lose the bus.
    function automatic logic trans_in_burst(input logic [W_TRANS-1:0] t);
        case (t)
            TRANS_SEQ, TRANS_BUSY: return 1'b1;
            default:               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_rr_priority_encoder.sv
// Round-robin search: first requester after 'last', wrapping modulo N_MASTER,
// with 'last' itself checked at the end.
module ahb_rr_priority_encoder
    import ahb_lite_slave_arbiter_pkg::*;
#(
    parameter int N_MASTER = 4,
    parameter int W_MASTER = 2
) (
    input  logic [N_MASTER-1:0] req,
    input  logic [W_MASTER-1:0] last,
    output logic                grant_valid,
    output logic [W_MASTER-1:0] grant_idx
);

    // Scan farthest-to-nearest so the nearest requester after 'last' overwrites.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = last;
        for (int k = N_MASTER; k >= 1; k--) begin
            grant_valid = grant_valid | req[(int'(last) + k) % N_MASTER];
            grant_idx   = req[(int'(last) + k) % N_MASTER] ?
                          W_MASTER'((int'(last) + k) % N_MASTER) : grant_idx;
        end
    end

endmodule

// File: rtl/ahb_lite_slave_arbiter.sv
// Arbitrates N_MASTER input stages onto one AHB-Lite slave port: registered
// one-hot ownership, burst/lock hold, round-robin between single transfers.
module ahb_lite_slave_arbiter
    import ahb_lite_slave_arbiter_pkg::*;
#(
    parameter int N_MASTER = 4,
    parameter int W_MASTER = 2,
    parameter int W_ADDR   = 32,
    parameter int W_DATA   = 32
) (
    input  logic                         HCLK,
    input  logic                         HRESET,
    input  logic [N_MASTER-1:0]          in_HSEL,
    input  logic [N_MASTER-1:0]          in_held_trans,
    input  logic [N_MASTER*W_TRANS-1:0]  in_HTRANS,
    input  logic [N_MASTER*W_BURST-1:0]  in_HBURST,
    input  logic [N_MASTER*W_SIZE-1:0]   in_HSIZE,
    input  logic [N_MASTER*W_PROT-1:0]   in_HPROT,
    input  logic [N_MASTER-1:0]          in_HMASTLOCK,
    input  logic [N_MASTER*W_ADDR-1:0]   in_HADDR,
    input  logic [N_MASTER-1:0]          in_HWRITE,
    input  logic [N_MASTER*W_DATA-1:0]   in_HWDATA,
    input  logic                         sl_HREADYOUT,
    input  logic [W_RESP-1:0]            sl_HRESP,
    input  logic [W_DATA-1:0]            sl_HRDATA,
    output logic [N_MASTER-1:0]          out_active,
    output logic                         out_HSEL,
    output logic [W_TRANS-1:0]           out_HTRANS,
    output logic [W_BURST-1:0]           out_HBURST,
    output logic [W_SIZE-1:0]            out_HSIZE,
    output logic [W_PROT-1:0]            out_HPROT,
    output logic                         out_HMASTLOCK,
    output logic [W_ADDR-1:0]            out_HADDR,
    output logic                         out_HWRITE,
    output logic [W_DATA-1:0]            out_HWDATA,
    output logic                         out_HREADY,
    output logic                         out_sl_HREADY,
    output logic [W_RESP-1:0]            out_sl_HRESP,
    output logic [W_DATA-1:0]            out_sl_HRDATA
);

    logic [N_MASTER-1:0] req_s;
    logic                own_req_s;
    logic [W_TRANS-1:0]  own_trans_s;
    logic                own_lock_s;
    logic                hold_s;
    logic                grant_valid_s;
    logic [W_MASTER-1:0] grant_idx_s;

    logic                valid_q,   valid_d;
    logic [W_MASTER-1:0] owner_q,   owner_d;
    logic [W_MASTER-1:0] rr_last_q, rr_last_d;
    logic                dvalid_q,  dvalid_d;
    logic [W_MASTER-1:0] downer_q,  downer_d;

    assign req_s       = in_HSEL & in_held_trans;
    assign own_req_s   = valid_q & req_s[owner_q];
    assign own_trans_s = in_HTRANS[int'(owner_q)*W_TRANS +: W_TRANS];
    assign own_lock_s  = in_HMASTLOCK[owner_q];
    assign hold_s      = own_req_s & (trans_in_burst(own_trans_s) | own_lock_s);

    assign out_HREADY    = sl_HREADYOUT;
    assign out_sl_HREADY = sl_HREADYOUT;
    assign out_sl_HRESP  = sl_HRESP;
    assign out_sl_HRDATA = sl_HRDATA;

    ahb_rr_priority_encoder #(
        .N_MASTER (N_MASTER),
        .W_MASTER (W_MASTER)
    ) u_rr (
        .req         (req_s),
        .last        (rr_last_q),
        .grant_valid (grant_valid_s),
        .grant_idx   (grant_idx_s)
    );

    // Ownership decode straight from flops, never from the request inputs.
    always_comb begin
        out_active = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            out_active[i] = valid_q & (int'(owner_q) == i);
        end
    end

    // Address/control mux; an owner that is not requesting presents IDLE.
    always_comb begin
        out_HSEL      = 1'b0;
        out_HTRANS    = TRANS_IDLE;
        out_HBURST    = BURST_SINGLE;
        out_HSIZE     = '0;
        out_HPROT     = '0;
        out_HMASTLOCK = 1'b0;
        out_HADDR     = '0;
        out_HWRITE    = 1'b0;
        if (own_req_s) begin
            out_HSEL      = 1'b1;
            out_HTRANS    = own_trans_s;
            out_HBURST    = in_HBURST[int'(owner_q)*W_BURST +: W_BURST];
            out_HSIZE     = in_HSIZE[int'(owner_q)*W_SIZE +: W_SIZE];
            out_HPROT     = in_HPROT[int'(owner_q)*W_PROT +: W_PROT];
            out_HMASTLOCK = own_lock_s;
            out_HADDR     = in_HADDR[int'(owner_q)*W_ADDR +: W_ADDR];
            out_HWRITE    = in_HWRITE[owner_q];
        end else begin
            out_HSEL      = 1'b0;
        end
    end

    // Write data follows whoever owned the address phase now in its data phase.
    always_comb begin
        if (dvalid_q) begin
            out_HWDATA = in_HWDATA[int'(downer_q)*W_DATA +: W_DATA];
        end else begin
            out_HWDATA = '0;
        end
    end

    // Next-state: everything advances only on HREADY edges.
    always_comb begin
        valid_d   = valid_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        dvalid_d  = dvalid_q;
        downer_d  = downer_q;
        if (sl_HREADYOUT) begin
            dvalid_d = out_HSEL & trans_is_xfer(out_HTRANS);
            downer_d = owner_q;
            if (hold_s) begin
                valid_d = 1'b1;
            end else if (grant_valid_s) begin
                valid_d   = 1'b1;
                owner_d   = grant_idx_s;
                rr_last_d = grant_idx_s;
            end else begin
                valid_d   = 1'b0;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers; reset makes master 0 the first round-robin candidate.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            valid_q   <= 1'b0;
            owner_q   <= '0;
            rr_last_q <= W_MASTER'(N_MASTER - 1);
            dvalid_q  <= 1'b0;
            downer_q  <= '0;
        end else begin
            valid_q   <= valid_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            dvalid_q  <= dvalid_d;
            downer_q  <= downer_d;
        end
    end

endmodule

// File: tb/tb_ahb_lite_slave_arbiter.sv
// Scoreboard bench for ahb_lite_slave_arbiter: directed scenarios plus random
// traffic, checked against a per-cycle behavioural model of the arbiter.
module tb_ahb_lite_slave_arbiter;
    import ahb_lite_slave_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int WM = 2;
    localparam int WA = 32;
    localparam int WD = 32;

    logic HCLK = 1'b0;
    logic HRESET;
    always #5 HCLK = ~HCLK;

    // Per-master stimulus
    logic        sel  [N];
    logic        held [N];
    logic [1:0]  trn  [N];
    logic [2:0]  bst  [N];
    logic [2:0]  siz  [N];
    logic [3:0]  prt  [N];
    logic        lck  [N];
    logic [31:0] adr  [N];
    logic        wr   [N];
    logic [31:0] wdat [N];
    logic        hreadyout;
    logic        rresp;
    logic [31:0] rdata;

    logic [N-1:0]      in_HSEL, in_held_trans, in_HMASTLOCK, in_HWRITE;
    logic [N*2-1:0]    in_HTRANS;
    logic [N*3-1:0]    in_HBURST, in_HSIZE;
    logic [N*4-1:0]    in_HPROT;
    logic [N*WA-1:0]   in_HADDR;
    logic [N*WD-1:0]   in_HWDATA;

    logic [N-1:0]  out_active;
    logic          out_HSEL, out_HMASTLOCK, out_HWRITE, out_HREADY, out_sl_HREADY;
    logic [1:0]    out_HTRANS;
    logic [2:0]    out_HBURST, out_HSIZE;
    logic [3:0]    out_HPROT;
    logic [WA-1:0] out_HADDR;
    logic [WD-1:0] out_HWDATA, out_sl_HRDATA;
    logic          out_sl_HRESP;

    always_comb begin
        in_HSEL = '0; in_held_trans = '0; in_HMASTLOCK = '0; in_HWRITE = '0;
        in_HTRANS = '0; in_HBURST = '0; in_HSIZE = '0; in_HPROT = '0;
        in_HADDR = '0; in_HWDATA = '0;
        for (int i = 0; i < N; i++) begin
            in_HSEL[i]            = sel[i];
            in_held_trans[i]      = held[i];
            in_HMASTLOCK[i]       = lck[i];
            in_HWRITE[i]          = wr[i];
            in_HTRANS[i*2 +: 2]   = trn[i];
            in_HBURST[i*3 +: 3]   = bst[i];
            in_HSIZE[i*3 +: 3]    = siz[i];
            in_HPROT[i*4 +: 4]    = prt[i];
            in_HADDR[i*WA +: WA]  = adr[i];
            in_HWDATA[i*WD +: WD] = wdat[i];
        end
    end

    ahb_lite_slave_arbiter #(.N_MASTER(N), .W_MASTER(WM), .W_ADDR(WA), .W_DATA(WD)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .in_HSEL(in_HSEL), .in_held_trans(in_held_trans), .in_HTRANS(in_HTRANS),
        .in_HBURST(in_HBURST), .in_HSIZE(in_HSIZE), .in_HPROT(in_HPROT),
        .in_HMASTLOCK(in_HMASTLOCK), .in_HADDR(in_HADDR), .in_HWRITE(in_HWRITE),
        .in_HWDATA(in_HWDATA),
        .sl_HREADYOUT(hreadyout), .sl_HRESP(rresp), .sl_HRDATA(rdata),
        .out_active(out_active), .out_HSEL(out_HSEL), .out_HTRANS(out_HTRANS),
        .out_HBURST(out_HBURST), .out_HSIZE(out_HSIZE), .out_HPROT(out_HPROT),
        .out_HMASTLOCK(out_HMASTLOCK), .out_HADDR(out_HADDR), .out_HWRITE(out_HWRITE),
        .out_HWDATA(out_HWDATA), .out_HREADY(out_HREADY),
        .out_sl_HREADY(out_sl_HREADY), .out_sl_HRESP(out_sl_HRESP), .out_sl_HRDATA(out_sl_HRDATA)
    );

    typedef struct {
        logic [3:0]  active;
        logic        hsel;
        logic [1:0]  trans;
        logic [2:0]  burst;
        logic [2:0]  size;
        logic [3:0]  prot;
        logic        lock;
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic        hready;
        logic        resp;
        logic [31:0] rdata;
    } exp_t;

    exp_t sbq[$];
    int checks   = 0;
    int failures = 0;

    // Model state: owner/data-owner as master number or -1 for none.
    int m_owner, m_last, m_downer;

    logic [3:0]  mon_active;
    logic        mon_hsel;
    logic [1:0]  mon_trans;
    logic [31:0] mon_haddr;
    logic [31:0] mon_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge HCLK);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("active",   32'(out_active),    32'(e.active));
                chk("hsel",     32'(out_HSEL),      32'(e.hsel));
                chk("htrans",   32'(out_HTRANS),    32'(e.trans));
                chk("hburst",   32'(out_HBURST),    32'(e.burst));
                chk("hsize",    32'(out_HSIZE),     32'(e.size));
                chk("hprot",    32'(out_HPROT),     32'(e.prot));
                chk("hlock",    32'(out_HMASTLOCK), 32'(e.lock));
                chk("haddr",    out_HADDR,          e.addr);
                chk("hwrite",   32'(out_HWRITE),    32'(e.write));
                chk("hwdata",   out_HWDATA,         e.wdata);
                chk("hready",   32'(out_HREADY),    32'(e.hready));
                chk("sl_hready",32'(out_sl_HREADY), 32'(e.hready));
                chk("sl_hresp", 32'(out_sl_HRESP),  32'(e.resp));
                chk("sl_hrdata",out_sl_HRDATA,      e.rdata);
                mon_active = out_active;
                mon_hsel   = out_HSEL;
                mon_trans  = out_HTRANS;
                mon_haddr  = out_HADDR;
                mon_wdata  = out_HWDATA;
            end
        end
    end

    // One bus cycle: predict this cycle's outputs, advance the model, wait an edge.
    task automatic step();
        exp_t e;
        bit   own_req;
        int   g;
        int   c;
        if (HRESET) begin
            m_owner = -1; m_last = N - 1; m_downer = -1;
        end
        own_req  = (m_owner >= 0) && sel[m_owner] && held[m_owner];
        e.active = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
        e.hsel = own_req; e.trans = 2'd0; e.burst = 3'd0; e.size = 3'd0;
        e.prot = 4'd0; e.lock = 1'b0; e.addr = 32'd0; e.write = 1'b0;
        if (own_req) begin
            e.trans = trn[m_owner]; e.burst = bst[m_owner]; e.size = siz[m_owner];
            e.prot  = prt[m_owner]; e.lock  = lck[m_owner]; e.addr = adr[m_owner];
            e.write = wr[m_owner];
        end
        e.wdata  = (m_downer >= 0) ? wdat[m_downer] : 32'd0;
        e.hready = hreadyout; e.resp = rresp; e.rdata = rdata;
        sbq.push_back(e);
        if (!HRESET && hreadyout) begin
            m_downer = (own_req && (trn[m_owner] == 2'd2 || trn[m_owner] == 2'd3)) ? m_owner : -1;
            if (own_req && (trn[m_owner] == 2'd3 || trn[m_owner] == 2'd1 || lck[m_owner])) begin
                m_owner = m_owner;
            end else begin
                g = -1;
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (g < 0 && sel[c] && held[c]) g = c;
                end
                if (g >= 0) begin m_owner = g; m_last = g; end
                else m_owner = -1;
            end
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) begin
            sel[i] = 1'b0; held[i] = 1'b0; trn[i] = TRANS_IDLE; bst[i] = BURST_SINGLE;
            siz[i] = 3'd2; prt[i] = 4'd3; lck[i] = 1'b0; adr[i] = 32'd0; wr[i] = 1'b0;
            wdat[i] = 32'hA000_0000 + 32'(i);
        end
    endtask

    task automatic drv(input int m, input logic [1:0] t, input logic [31:0] a);
        sel[m] = 1'b1; held[m] = 1'b1; trn[m] = t; adr[m] = a;
    endtask

    task automatic drop(input int m);
        sel[m] = 1'b0; held[m] = 1'b0; trn[m] = TRANS_IDLE; lck[m] = 1'b0;
    endtask

    task automatic reset_pulse();
        HRESET = 1'b1; idle_all(); step(); HRESET = 1'b0;
    endtask

    logic [3:0] seq032 [6];

    initial begin
        HRESET = 1'b1; hreadyout = 1'b1; rresp = 1'b0; rdata = 32'h1234_5678;
        idle_all();
        seq032[0] = 4'b0001; seq032[1] = 4'b0010; seq032[2] = 4'b1000;
        seq032[3] = 4'b0001; seq032[4] = 4'b0010; seq032[5] = 4'b1000;
        @(posedge HCLK); #1;
        step();
        chk("reset_active", 32'(mon_active), 32'd0);
        step();
        HRESET = 1'b0;

        // Single NONSEQ from master 0 after reset release
        drv(0, TRANS_NONSEQ, 32'h0000_1000);
        step(); chk("s031_pre_active", 32'(mon_active), 32'd0);
        step(); chk("s031_active", 32'(mon_active), 32'b0001);
        chk("s031_haddr", mon_haddr, 32'h0000_1000);
        chk("s031_hsel", 32'(mon_hsel), 32'd1);
        drop(0); step();

        // Round-robin among masters 0, 1, 3
        reset_pulse();
        drv(0, TRANS_NONSEQ, 32'h100); drv(1, TRANS_NONSEQ, 32'h200); drv(3, TRANS_NONSEQ, 32'h300);
        step();
        for (int k = 0; k < 6; k++) begin
            step(); chk("s032_rr_grant", 32'(mon_active), 32'(seq032[k]));
        end
        idle_all(); step();

        // INCR4 from master 2 is not split by master 1
        reset_pulse();
        drv(2, TRANS_NONSEQ, 32'h2000); bst[2] = BURST_INCR4;
        step();
        step(); chk("s033_beat0", 32'(mon_active), 32'b0100);
        drv(1, TRANS_NONSEQ, 32'h1100);
        for (int b = 1; b < 4; b++) begin
            drv(2, TRANS_SEQ, 32'h2000 + 32'(b * 4));
            step(); chk("s033_beat", 32'(mon_active), 32'b0100);
        end
        drop(2); step(); chk("s033_tail", 32'(mon_active), 32'b0100);
        step(); chk("s033_m1_grant", 32'(mon_active), 32'b0010);
        idle_all(); step();

        // Master 1 write with two wait states in its data phase
        reset_pulse();
        drv(1, TRANS_NONSEQ, 32'h3000); wr[1] = 1'b1; wdat[1] = 32'hDEAD_BEEF; wdat[0] = 32'h0BAD_F00D;
        step();
        step(); chk("s034_addr_phase", 32'(mon_active), 32'b0010);
        drop(1); drv(0, TRANS_NONSEQ, 32'h3100); hreadyout = 1'b0;
        for (int w = 0; w < 2; w++) begin
            step(); chk("s034_wait_owner", 32'(mon_active), 32'b0010);
            chk("s034_wait_wdata", mon_wdata, 32'hDEAD_BEEF);
        end
        hreadyout = 1'b1;
        step(); chk("s034_last_owner", 32'(mon_active), 32'b0010);
        chk("s034_last_wdata", mon_wdata, 32'hDEAD_BEEF);
        step(); chk("s034_m0_grant", 32'(mon_active), 32'b0001);
        idle_all(); step();

        // Locked NONSEQs from master 3 hold off master 0
        reset_pulse();
        drv(3, TRANS_NONSEQ, 32'h4000); lck[3] = 1'b1;
        step();
        drv(0, TRANS_NONSEQ, 32'h4400);
        for (int l = 0; l < 3; l++) begin
            adr[3] = 32'h4000 + 32'(l * 4);
            step(); chk("s035_locked", 32'(mon_active), 32'b1000);
        end
        drop(3); step(); chk("s035_unlock", 32'(mon_active), 32'b1000);
        step(); chk("s035_m0_grant", 32'(mon_active), 32'b0001);
        idle_all(); step();

        // Reset in the middle of a burst
        reset_pulse();
        drv(2, TRANS_NONSEQ, 32'h5000); bst[2] = BURST_INCR4;
        step();
        step(); chk("s036_beat0", 32'(mon_active), 32'b0100);
        drv(2, TRANS_SEQ, 32'h5004);
        step(); chk("s036_beat1", 32'(mon_active), 32'b0100);
        drv(0, TRANS_NONSEQ, 32'h10); drv(1, TRANS_NONSEQ, 32'h20); drv(3, TRANS_NONSEQ, 32'h30);
        drv(2, TRANS_SEQ, 32'h5008);
        HRESET = 1'b1;
        step(); chk("s036_rst_active", 32'(mon_active), 32'd0);
        chk("s036_rst_htrans", 32'(mon_trans), 32'(TRANS_IDLE));
        HRESET = 1'b0; drv(2, TRANS_NONSEQ, 32'h5000);
        step(); chk("s036_post_none", 32'(mon_active), 32'd0);
        step(); chk("s036_post_m0", 32'(mon_active), 32'b0001);
        idle_all(); step();

        // Random traffic against the model
        reset_pulse();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < N; i++) begin
                sel[i]  = 1'($urandom_range(0, 3) != 0);
                held[i] = 1'($urandom_range(0, 3) != 0);
                trn[i]  = 2'($urandom_range(0, 3));
                bst[i]  = 3'($urandom_range(0, 7));
                siz[i]  = 3'($urandom_range(0, 7));
                prt[i]  = 4'($urandom_range(0, 15));
                lck[i]  = 1'($urandom_range(0, 7) == 0);
                adr[i]  = $urandom();
                wr[i]   = 1'($urandom_range(0, 1));
                wdat[i] = $urandom();
            end
            hreadyout = 1'($urandom_range(0, 3) != 0);
            rresp     = 1'($urandom_range(0, 1));
            rdata     = $urandom();
            HRESET    = 1'($urandom_range(0, 199) == 0);
            step();
        end
        HRESET = 1'b0; hreadyout = 1'b1; idle_all(); step();

        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
